// File: rtl/ram_sdp_be_if.sv
// Bus bundle for the simple-dual-port byte-enable RAM.
// master: drives write/read requests, observes read data, read strobe and clear status.
// slave : the RAM side.
interface ram_sdp_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

    logic                  wrt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] datain;
    logic [NUM_BYTES-1:0]  wr_be;
    logic                  rdd;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  rd_valid;
    logic                  init_busy;

    modport master (
        output wrt, wr_addr, datain, wr_be, rdd, rd_addr,
        input  dataout, rd_valid, init_busy
    );

    modport slave (
        input  wrt, wr_addr, datain, wr_be, rdd, rd_addr,
        output dataout, rd_valid, init_busy
    );
endinterface

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with per-byte write enables, selectable read latency (1 or 2),
// selectable same-address read-during-write result and a post-reset clear sequencer.
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-high reset
//   bus.wrt/wr_addr/datain/wr_be - write request, address, data, byte enables
//   bus.rdd/rd_addr              - read request and address
//   bus.dataout/rd_valid         - registered read data and one-cycle-per-read strobe
//   bus.init_busy                - clear sequencer active, requests dropped
module ram_sdp_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned RD_LATENCY     = 1,
    parameter bit          RDW_MODE       = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    ram_sdp_be_if.slave   bus
);
    localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  init_busy_q;

    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic                  clr_we_c;
    logic                  collide_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    // Request qualification; nothing is accepted while clearing or in reset.
    assign wr_acc_c  = (state == ST_IDLE) && bus.wrt && !rst;
    assign rd_acc_c  = (state == ST_IDLE) && bus.rdd && !rst;
    assign clr_we_c  = (state == ST_CLEAR) && !rst;
    assign collide_c = wr_acc_c && rd_acc_c && (bus.wr_addr == bus.rd_addr);

    // Clear sequencer: walks every address once after reset, then parks in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            cnt         <= '0;
            init_busy_q <= CLEAR_ON_RESET;
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + ADDR_WIDTH'(1);
                    if (cnt == LAST_ADDR) begin
                        state       <= ST_IDLE;
                        init_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // One narrow array per byte lane so each lane has its own write enable.
    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_lane
        logic [BYTE_WIDTH-1:0] lane_mem [DEPTH];
        logic [BYTE_WIDTH-1:0] lane_wdata;

        assign lane_wdata = bus.datain[b*BYTE_WIDTH +: BYTE_WIDTH];

        always_ff @(posedge clk) begin
            if (clr_we_c) begin
                lane_mem[cnt] <= '0;
            end else if (wr_acc_c && bus.wr_be[b]) begin
                lane_mem[bus.wr_addr] <= lane_wdata;
            end
        end

        // Write-first forwards only the enabled new bytes on a same-address collision.
        assign rd_word_c[b*BYTE_WIDTH +: BYTE_WIDTH] =
            (RDW_MODE && collide_c && bus.wr_be[b]) ? lane_wdata : lane_mem[bus.rd_addr];
    end

    // First read stage: array sampled at the accepting edge; data held between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_acc_c;
            if (rd_acc_c) begin
                s1_data <= rd_word_c;
            end
        end
    end

    // Optional output register stage; any value other than 2 means single-cycle latency.
    if (RD_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign bus.dataout  = s2_data;
        assign bus.rd_valid = s2_valid;
    end else begin : g_lat1
        assign bus.dataout  = s1_data;
        assign bus.rd_valid = s1_valid;
    end

    assign bus.init_busy = init_busy_q;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Scoreboard bench: two RAM instances (latency 1 / read-first, latency 2 / write-first)
// share one stimulus stream; a word-array reference model predicts each read result
// and the edge it must appear after, and a negedge monitor checks both instances.
module tb_ram_sdp_be;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned NB    = DW / BW;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrt;
    logic          rdd;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] datain;
    logic [NB-1:0] wr_be;

    always #5 clk = ~clk;

    ram_sdp_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus_a ();
    ram_sdp_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus_b ();

    assign bus_a.wrt = wrt;  assign bus_a.wr_addr = wr_addr; assign bus_a.datain = datain;
    assign bus_a.wr_be = wr_be; assign bus_a.rdd = rdd; assign bus_a.rd_addr = rd_addr;
    assign bus_b.wrt = wrt;  assign bus_b.wr_addr = wr_addr; assign bus_b.datain = datain;
    assign bus_b.wr_be = wr_be; assign bus_b.rdd = rdd; assign bus_b.rd_addr = rd_addr;

    ram_sdp_be #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
        .RD_LATENCY(1), .RDW_MODE(1'b0), .CLEAR_ON_RESET(1'b1)
    ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

    ram_sdp_be #(
        .DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
        .RD_LATENCY(2), .RDW_MODE(1'b1), .CLEAR_ON_RESET(1'b1)
    ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb [2][$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_exp [2];
    bit            started  = 1'b0;
    bit            clr_on   = 1'b0;
    bit            exp_busy = 1'b0;
    int            clr_addr = 0;
    int            edge_n   = 0;
    int            n_cmp    = 0;
    int            n_bad    = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < int'(NB); i++)
            if (be[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
        return r;
    endfunction

    // Drive one cycle of inputs, then advance the reference model at the edge.
    task automatic step(input bit r, input bit w, input bit rd, input logic [AW-1:0] wa,
                        input logic [DW-1:0] d, input logic [NB-1:0] be,
                        input logic [AW-1:0] ra);
        logic [DW-1:0] old_w;
        logic [DW-1:0] new_w;
        rst = r; wrt = w; rdd = rd; wr_addr = wa; datain = d; wr_be = be; rd_addr = ra;
        @(posedge clk);
        if (r) begin
            started  = 1'b1;
            clr_on   = 1'b1;
            clr_addr = 0;
            exp_busy = 1'b1;
            for (int p = 0; p < 2; p++) begin
                sb[p].delete();
                last_exp[p] = '0;
            end
        end else if (clr_on) begin
            ref_mem[AW'(clr_addr)] = '0;
            clr_addr++;
            if (clr_addr == int'(DEPTH)) begin
                clr_on   = 1'b0;
                exp_busy = 1'b0;
            end
        end else begin
            old_w = ref_mem[ra];
            new_w = w ? merge(ref_mem[wa], d, be) : ref_mem[wa];
            if (rd) begin
                sb[0].push_back('{old_w, edge_n + 1});
                sb[1].push_back('{(w && wa == ra) ? new_w : old_w, edge_n + 2});
            end
            if (w) ref_mem[wa] = new_w;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        step(1'b0, 1'b1, 1'b0, a, d, be, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 1'b1, '0, '0, '0, a);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // Monitor: busy flag every cycle, read results on rd_valid, data hold otherwise.
    always @(negedge clk) begin : monitor
        logic          v;
        logic          bsy;
        logic [DW-1:0] d;
        exp_t          e;
        if (started) begin
            for (int p = 0; p < 2; p++) begin
                v   = (p == 0) ? bus_a.rd_valid  : bus_b.rd_valid;
                bsy = (p == 0) ? bus_a.init_busy : bus_b.init_busy;
                d   = (p == 0) ? bus_a.dataout   : bus_b.dataout;
                n_cmp++;
                if (bsy !== exp_busy) begin
                    n_bad++;
                    $display("FAIL init_busy dut%0d edge %0d: got %b required %b", p, edge_n, bsy, exp_busy);
                end
                n_cmp++;
                if (v === 1'b1) begin
                    if (sb[p].size() == 0) begin
                        n_bad++;
                        $display("FAIL spurious_valid dut%0d edge %0d: got rd_valid=1 data %h required rd_valid=0", p, edge_n, d);
                    end else begin
                        e = sb[p].pop_front();
                        if (d !== e.data || edge_n != e.due) begin
                            n_bad++;
                            $display("FAIL read_data dut%0d: got %h at edge %0d required %h at edge %0d", p, d, edge_n, e.data, e.due);
                        end
                        last_exp[p] = e.data;
                    end
                end else if (v !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rd_valid_x dut%0d edge %0d: got %b required 0 or 1", p, edge_n, v);
                end else if (sb[p].size() != 0 && sb[p][0].due <= edge_n) begin
                    n_bad++;
                    $display("FAIL missing_valid dut%0d edge %0d: got rd_valid=0 required data %h", p, edge_n, sb[p][0].data);
                    void'(sb[p].pop_front());
                end else if (d !== last_exp[p]) begin
                    n_bad++;
                    $display("FAIL dataout_hold dut%0d edge %0d: got %h required %h", p, edge_n, d, last_exp[p]);
                end
            end
        end
    end

    initial begin
        // Power-up reset; requests during the clear must be dropped.
        do_reset();
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++)
            step(1'b0, 1'b1, 1'b1, AW'(2), 32'hFFFF_FFFF, '1, AW'(2));
        for (int i = 0; i < 40 && exp_busy; i++) idle(1);
        rd(AW'(2));
        idle(3);

        // Clear after a mid-life reset wipes previously written data.
        wr(AW'(3), 32'hDEAD_BEEF, '1);
        rd(AW'(3));
        do_reset();
        idle(int'(DEPTH));
        for (int a = 0; a < int'(DEPTH); a++) rd(AW'(a));
        idle(3);

        // Byte enables.
        wr(AW'(1), 32'h1122_3344, 4'b1111);
        wr(AW'(1), 32'hAABB_CCDD, 4'b0101);
        rd(AW'(1));
        wr(AW'(1), 32'h5566_7788, 4'b0000);
        rd(AW'(1));
        idle(3);

        // Same-address read-during-write, then a follow-up read.
        step(1'b0, 1'b1, 1'b1, AW'(5), 32'hCAFE_F00D, 4'b1111, AW'(5));
        rd(AW'(5));
        idle(3);

        // Streaming reads of preloaded addresses.
        for (int a = 0; a < 8; a++) wr(AW'(a), DW'(a), '1);
        for (int a = 0; a < 8; a++) rd(AW'(a));
        idle(4);

        // Reset one cycle after a read: in-flight result must be dropped.
        rd(AW'(3));
        do_reset();
        idle(int'(DEPTH) + 2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 149) == 0), 1'(($urandom_range(0, 2) != 0)),
                 1'(($urandom_range(0, 2) != 0)), AW'($urandom_range(0, 3)), DW'($urandom),
                 NB'($urandom), AW'($urandom_range(0, 3)));
        end
        idle(int'(DEPTH) + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
